spi_master: RTL and testbench
=============================

# spi_master

Parametrised SPI master, successor to the fixed-mode 8-bit SPI core: configurable word width, SCLK divider and slave-select count, with all four SPI modes selectable per transfer. Sits between the host register bus (cs/rd/wr strobes) and external SPI slaves. Each bus write launches one full-duplex word transfer framed by a dedicated active-low slave select. A sticky `done` flag signals completion.

## Interface
- `DWIDTH`, 8, word width in bits (≥2)
- `CLK_DIV`, 4, clk cycles per SCLK half-period (≥2)
- `NUM_SS`, 1, number of slave-select outputs (≥1)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cs`  in  1  block select
- `rd`  in  1  read strobe; `cs & rd & ~wr` clears `done`
- `wr`  in  1  write strobe; `cs & wr & ~rd` in IDLE starts a transfer
- `din`  in  DWIDTH  transmit word, latched at start
- `cpol`  in  1  clock polarity, latched at start
- `cpha`  in  1  clock phase, latched at start
- `ss_sel`  in  max(1,$clog2(NUM_SS))  slave index, latched at start
- `dout`  out  DWIDTH  last received word
- `busy`  out  1  transfer in progress
- `done`  out  1  sticky completion flag
- `miso`  in  1  serial in
- `mosi`  out  1  serial out
- `sclk`  out  1  SPI clock
- `ss_n`  out  NUM_SS  active-low slave selects

## Operation
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE: `sclk` registered from live `cpol`; `ss_n` all 1; `busy`=0. Start condition: latch `din` into tx shift, latch `cpol/cpha/ss_sel`, clear `done`, go SETUP, `busy`=1.
- SETUP (CLK_DIV cycles): `ss_n[ss_sel]`=0, `sclk` idle level, `mosi` = tx MSB.
- XFER: `sclk` toggles every CLK_DIV cycles, exactly 2*DWIDTH edges; odd edges leading, even edges trailing.
  - CPHA=0: sample `miso` on leading edges; shift tx on trailing edges.
  - CPHA=1: shift tx on leading edges 2..DWIDTH (first leading edge no shift); sample on trailing edges.
  - Received bits shift into separate rx register, MSB first; exactly DWIDTH samples.
- HOLD (CLK_DIV cycles): `sclk` idle, select still asserted. On exit: `ss_n` all 1, `dout` ← rx, `done`=1, `busy`=0, IDLE.
- `wr` while busy: ignored, no effect on any state. `rd` and `wr` together: no operation.
- Clear and start in same cycle impossible to conflict: start clears `done`; `done` set at HOLD exit wins over a simultaneous clear.
- `ss_sel` ≥ NUM_SS: no select asserted; transfer runs normally.
- Counters: divider `$clog2(CLK_DIV)` bits, down-count from CLK_DIV-1; edge counter `$clog2(2*DWIDTH)+1` bits, down-count, no wrap.

## Timing
- Reset values: `ss_n` all 1, `sclk` 0, `mosi` 0, `dout` 0, `done` 0, `busy` 0; state IDLE.
- Start accepted at edge T: `busy`=1, `ss_n` low visible after T+1 edge.
- First SCLK edge after T+1+CLK_DIV; last after T+1+CLK_DIV*(2*DWIDTH).
- `done`/`dout`/`ss_n` release after T+1+CLK_DIV*(2*DWIDTH+2); DWIDTH=8, CLK_DIV=4 → T+73.
- Next start accepted earliest one cycle after return to IDLE.
- Reset mid-transfer: immediate abort to reset values; `done` not set, `dout` unchanged from 0.

## Configuration
- `SPI_LSB_FIRST_EN`: defined → extra input `lsb_first` (1 bit, latched at start); when 1, tx shifts LSB first and rx fills LSB first. Undefined → port absent, always MSB first.

## Test plan
- Mode 0, `din`=8'hA5, `miso` looped to `mosi` → `dout`=8'hA5, `done`=1 at T+73, 16 SCLK edges, `sclk` idle 0.
- Mode 3 and mode 1 against slave model returning 8'h3C → `dout`=8'h3C; `sclk` idle 1 in mode 3; `mosi` stable at every sampling edge.
- `wr` with `din`=8'hFF mid-transfer of 8'h12 → ignored; loopback `dout`=8'h12.
- `rst` low at cycle 30 of transfer → all outputs reset values next cycle, no `done`; subsequent transfer completes correctly.
- NUM_SS=2, `ss_sel`=1 → only `ss_n[1]` low, for 72 cycles; `rd` afterwards clears `done`.
- With `SPI_LSB_FIRST_EN`, `lsb_first`=1, `din`=8'h01 → first `mosi` bit 1, loopback `dout`=8'h01.

Source files
------------

// File: rtl/spi_master_if.sv
// ============================================================
// spi_master_if: host-side register bus bundle for spi_master
// Revision: 1.0
// ============================================================
`default_nettype none

interface spi_master_if #(
  parameter int DWIDTH = 8,
  parameter int NUM_SS = 1
);
  localparam int SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic              cs;
  logic              rd;
  logic              wr;
  logic [DWIDTH-1:0] din;
  logic              cpol;
  logic              cpha;
  logic [SSW-1:0]    ss_sel;
`ifdef SPI_LSB_FIRST_EN
  logic              lsb_first;
`endif
  logic [DWIDTH-1:0] dout;
  logic              busy;
  logic              done;

  modport master (
`ifdef SPI_LSB_FIRST_EN
    output lsb_first,
`endif
    output cs, rd, wr, din, cpol, cpha, ss_sel,
    input  dout, busy, done
  );

  modport slave (
`ifdef SPI_LSB_FIRST_EN
    input  lsb_first,
`endif
    input  cs, rd, wr, din, cpol, cpha, ss_sel,
    output dout, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================
// spi_master: full-duplex SPI master, modes 0-3, optional SPI_LSB_FIRST_EN
// Revision: 1.0
// ============================================================
`default_nettype none

module spi_master #(
  parameter int DWIDTH  = 8,
  parameter int CLK_DIV = 4,
  parameter int NUM_SS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_if.slave       bus,
  input  logic              miso,
  output logic              mosi,
  output logic              sclk,
  output logic [NUM_SS-1:0] ss_n
);
  localparam int SSW   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int ECW   = $clog2(2 * DWIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [ECW-1:0]   EDGES    = ECW'(2 * DWIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] tx_sh;
  logic [DWIDTH-1:0] rx_sh;
  logic [DWIDTH-1:0] dout_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              cpol_l;
  logic              cpha_l;
  logic              lsb_l;
  logic [SSW-1:0]    sel_l;
  logic [DIV_W-1:0]  div;
  logic [ECW-1:0]    edge_cnt;
  logic [NUM_SS-1:0] sel_dec;

  logic              start;
  logic              clr;
  logic              leading;
  logic              do_shift;
  logic              do_sample;
  logic [DWIDTH-1:0] tx_next;
  logic [DWIDTH-1:0] rx_next;

  assign start = bus.cs & bus.wr & ~bus.rd;
  assign clr   = bus.cs & bus.rd & ~bus.wr;

  // Edge counter starts at 2*DWIDTH, so odd (leading) edges see an even count
  assign leading   = ~edge_cnt[0];
  assign do_shift  = leading ? (cpha_l && (edge_cnt != EDGES)) : ~cpha_l;
  assign do_sample = leading ^ cpha_l;
  assign tx_next   = lsb_l ? {1'b0, tx_sh[DWIDTH-1:1]} : {tx_sh[DWIDTH-2:0], 1'b0};
  assign rx_next   = lsb_l ? {miso, rx_sh[DWIDTH-1:1]} : {rx_sh[DWIDTH-2:0], miso};

  assign bus.dout = dout_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

  generate
    for (genvar i = 0; i < NUM_SS; i++) begin : g_ss
      assign sel_dec[i] = (sel_l == SSW'(i));
    end
  endgenerate

  function automatic logic first_bit(input logic [DWIDTH-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DWIDTH-1];
  endfunction

`ifdef SPI_LSB_FIRST_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lsb_l <= 1'b0;
    else if (state == IDLE && start)
      lsb_l <= bus.lsb_first;
  end
`else
  assign lsb_l = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx_sh    <= '0;
      rx_sh    <= '0;
      dout_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      sel_l    <= '0;
      div      <= DIV_LOAD;
      edge_cnt <= '0;
      ss_n     <= '1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      // A completion in HOLD below overrides this clear
      if (clr)
        done_reg <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= bus.cpol;
          ss_n <= '1;
          if (start) begin
            tx_sh    <= bus.din;
            rx_sh    <= '0;
            cpol_l   <= bus.cpol;
            cpha_l   <= bus.cpha;
            sel_l    <= bus.ss_sel;
            div      <= DIV_LOAD;
            done_reg <= 1'b0;
            busy_reg <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          ss_n <= ~sel_dec;
          sclk <= cpol_l;
          mosi <= first_bit(tx_sh, lsb_l);
          // Divider left at zero so the first SCLK edge lands on the next cycle
          if (div == '0) begin
            edge_cnt <= EDGES;
            state    <= XFER;
          end else begin
            div <= div - 1'b1;
          end
        end
        XFER: begin
          if (div == '0) begin
            div <= DIV_LOAD;
            if (edge_cnt == '0) begin
              state <= HOLD;
            end else begin
              sclk     <= ~sclk;
              edge_cnt <= edge_cnt - 1'b1;
              if (do_shift) begin
                tx_sh <= tx_next;
                mosi  <= first_bit(tx_next, lsb_l);
              end
              if (do_sample)
                rx_sh <= rx_next;
            end
          end else begin
            div <= div - 1'b1;
          end
        end
        HOLD: begin
          sclk <= cpol_l;
          if (div == '0) begin
            ss_n     <= '1;
            dout_reg <= rx_sh;
            done_reg <= 1'b1;
            busy_reg <= 1'b0;
            state    <= IDLE;
          end else begin
            div <= div - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================
// tb_spi_master: directed self-checking bench for spi_master (DWIDTH=8, CLK_DIV=4, NUM_SS=3)
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_spi_master;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       miso;
  logic       mosi;
  logic       sclk;
  logic [2:0] ss_n;
  logic       loop = 1'b1;

  int n_run  = 0;
  int n_fail = 0;
  int edges  = 0;

  logic [7:0] sl_sh = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic       sl_out = 1'b0;
  logic       lead;
  wire        ss_all = &ss_n;

  always #5 clk = ~clk;

  spi_master_if #(.DWIDTH(8), .NUM_SS(3)) bus ();

  spi_master #(.DWIDTH(8), .CLK_DIV(4), .NUM_SS(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .miso (miso),
    .mosi (mosi),
    .sclk (sclk),
    .ss_n (ss_n)
  );

  assign miso = loop ? mosi : sl_out;

  // Behavioural slave returning 8'h3C and capturing mosi on its sampling edges
  always @(negedge ss_all) begin
    sl_sh = 8'h3C;
    sl_rx = 8'h00;
    if (!bus.cpha) sl_out = sl_sh[7];
  end

  always @(sclk) begin
    edges++;
    if (!ss_all) begin
      lead = (sclk !== bus.cpol);
      if (lead ^ bus.cpha) begin
        sl_rx = {sl_rx[6:0], mosi};
      end else if (bus.cpha) begin
        sl_out = sl_sh[7];
        sl_sh  = sl_sh << 1;
      end else begin
        sl_sh  = sl_sh << 1;
        sl_out = sl_sh[7];
      end
    end
  end

  // Caller is at a negedge; returns just after the accepting edge T
  task automatic start(input logic [7:0] d, input logic pol, input logic pha,
                       input logic [1:0] sel, input logic lp);
    bus.din = d; bus.cpol = pol; bus.cpha = pha; bus.ss_sel = sel; loop = lp;
    bus.cs = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.wr = 1'b0;
    edges = 0;
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_run++;
    if ({ss_n, sclk, mosi, bus.busy, bus.done} !== 7'b1110000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ss_n/sclk/mosi/busy/done=%b, want 1110000",
               {ss_n, sclk, mosi, bus.busy, bus.done});
    end
    n_run++;
    if (bus.dout !== 8'h00) begin
      n_fail++; $display("FAIL reset_dout: got %h, want 00", bus.dout);
    end
    rst = 1'b1;
    go(1);
  endtask

  task automatic test_mode0;
    start(8'hA5, 1'b0, 1'b0, 2'd0, 1'b1);
    go(0);
    n_run++;
    if ({bus.busy, ss_n} !== 4'b1111) begin
      n_fail++; $display("FAIL m0_T: got busy/ss_n=%b, want 1111", {bus.busy, ss_n});
    end
    go(1);
    n_run++;
    if ({ss_n, mosi} !== 4'b1101) begin
      n_fail++; $display("FAIL m0_T1: got ss_n/mosi=%b, want 1101", {ss_n, mosi});
    end
    go(3);
    n_run++;
    if (sclk !== 1'b0) begin
      n_fail++; $display("FAIL m0_T4_sclk: got %b, want 0", sclk);
    end
    go(1);
    n_run++;
    if (sclk !== 1'b1) begin
      n_fail++; $display("FAIL m0_T5_sclk: got %b, want 1", sclk);
    end
    go(67);
    n_run++;
    if ({bus.done, bus.busy} !== 2'b01 || edges != 16) begin
      n_fail++;
      $display("FAIL m0_T72: got done/busy=%b edges=%0d, want 01 and 16",
               {bus.done, bus.busy}, edges);
    end
    go(1);
    n_run++;
    if ({bus.done, bus.busy, ss_n, sclk} !== 6'b101110 || bus.dout !== 8'hA5) begin
      n_fail++;
      $display("FAIL m0_T73: got done/busy/ss_n/sclk=%b dout=%h, want 101110 and A5",
               {bus.done, bus.busy, ss_n, sclk}, bus.dout);
    end
  endtask

  task automatic test_mode3_mode1;
    start(8'hC3, 1'b1, 1'b1, 2'd0, 1'b0);
    go(5);
    n_run++;
    if (sclk !== 1'b0) begin
      n_fail++; $display("FAIL m3_first_edge: got sclk=%b, want 0", sclk);
    end
    go(68);
    n_run++;
    if (bus.dout !== 8'h3C || sl_rx !== 8'hC3 || sclk !== 1'b1 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL m3_result: got dout=%h slave_rx=%h sclk=%b done=%b, want 3C C3 1 1",
               bus.dout, sl_rx, sclk, bus.done);
    end
    start(8'h96, 1'b0, 1'b1, 2'd0, 1'b0);
    go(73);
    n_run++;
    if (bus.dout !== 8'h3C || sl_rx !== 8'h96 || sclk !== 1'b0 || edges != 16) begin
      n_fail++;
      $display("FAIL m1_result: got dout=%h slave_rx=%h sclk=%b edges=%0d, want 3C 96 0 16",
               bus.dout, sl_rx, sclk, edges);
    end
  endtask

  task automatic test_wr_ignored;
    start(8'h12, 1'b0, 1'b0, 2'd0, 1'b1);
    go(20);
    bus.din = 8'hFF; bus.cs = 1'b1; bus.wr = 1'b1;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.wr = 1'b0;
    go(0);
    n_run++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL wr_busy: got %b, want 1", bus.busy);
    end
    go(52);
    n_run++;
    if (bus.dout !== 8'h12 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ignored: got dout=%h done=%b, want 12 1", bus.dout, bus.done);
    end
  endtask

  task automatic test_reset_abort;
    start(8'h77, 1'b0, 1'b0, 2'd0, 1'b1);
    go(30);
    n_run++;
    if (sclk !== 1'b1) begin
      n_fail++; $display("FAIL abort_mid_sclk: got %b, want 1", sclk);
    end
    rst = 1'b0;
    #1;
    n_run++;
    if ({ss_n, sclk, mosi, bus.busy, bus.done} !== 7'b1110000 || bus.dout !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_state: got ss_n/sclk/mosi/busy/done=%b dout=%h, want 1110000 00",
               {ss_n, sclk, mosi, bus.busy, bus.done}, bus.dout);
    end
    go(2);
    n_run++;
    if (bus.done !== 1'b0 || ss_n !== 3'b111) begin
      n_fail++; $display("FAIL abort_hold: got done=%b ss_n=%b, want 0 111", bus.done, ss_n);
    end
    rst = 1'b1;
    go(1);
    start(8'h5A, 1'b0, 1'b0, 2'd0, 1'b1);
    go(73);
    n_run++;
    if (bus.dout !== 8'h5A || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_recover: got dout=%h done=%b, want 5A 1", bus.dout, bus.done);
    end
  endtask

  task automatic test_select;
    int low_cnt;
    start(8'hE7, 1'b0, 1'b0, 2'd1, 1'b1);
    go(1);
    n_run++;
    if (ss_n !== 3'b101) begin
      n_fail++; $display("FAIL sel1_assert: got ss_n=%b, want 101", ss_n);
    end
    low_cnt = (ss_n == 3'b101) ? 1 : 0;
    for (int k = 2; k <= 72; k++) begin
      go(1);
      if (ss_n == 3'b101) low_cnt++;
    end
    bus.cs = 1'b1; bus.rd = 1'b1;
    go(1);
    n_run++;
    if (low_cnt != 72 || ss_n !== 3'b111 || bus.done !== 1'b1 || bus.dout !== 8'hE7) begin
      n_fail++;
      $display("FAIL sel1_frame: got low_cycles=%0d ss_n=%b done=%b dout=%h, want 72 111 1 E7",
               low_cnt, ss_n, bus.done, bus.dout);
    end
    bus.wr = 1'b1;
    go(1);
    n_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rdwr_noop: got done=%b busy=%b, want 1 0", bus.done, bus.busy);
    end
    bus.wr = 1'b0;
    go(1);
    n_run++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL rd_clear: got done=%b, want 0", bus.done);
    end
    bus.cs = 1'b0; bus.rd = 1'b0;
    go(1);
  endtask

  task automatic test_unselected;
    start(8'h69, 1'b0, 1'b0, 2'd3, 1'b1);
    go(10);
    n_run++;
    if (ss_n !== 3'b111 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL sel3_none: got ss_n=%b busy=%b, want 111 1", ss_n, bus.busy);
    end
    go(63);
    n_run++;
    if (bus.dout !== 8'h69 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL sel3_result: got dout=%h done=%b, want 69 1", bus.dout, bus.done);
    end
  endtask

  task automatic test_back_to_back;
    start(8'h81, 1'b1, 1'b0, 2'd2, 1'b1);
    go(0);
    n_run++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", bus.busy, bus.done);
    end
    go(73);
    n_run++;
    if (bus.dout !== 8'h81 || sclk !== 1'b1 || ss_n !== 3'b111 || edges != 16) begin
      n_fail++;
      $display("FAIL b2b_result: got dout=%h sclk=%b ss_n=%b edges=%0d, want 81 1 111 16",
               bus.dout, sclk, ss_n, edges);
    end
  endtask

`ifdef SPI_LSB_FIRST_EN
  task automatic test_lsb_first;
    bus.lsb_first = 1'b1;
    start(8'h01, 1'b0, 1'b0, 2'd0, 1'b1);
    go(1);
    n_run++;
    if (mosi !== 1'b1) begin
      n_fail++; $display("FAIL lsb_first_bit: got mosi=%b, want 1", mosi);
    end
    go(72);
    n_run++;
    if (bus.dout !== 8'h01) begin
      n_fail++; $display("FAIL lsb_loop01: got dout=%h, want 01", bus.dout);
    end
    start(8'h80, 1'b0, 1'b1, 2'd0, 1'b0);
    go(1);
    n_run++;
    if (mosi !== 1'b0) begin
      n_fail++; $display("FAIL lsb_first_bit80: got mosi=%b, want 0", mosi);
    end
    go(72);
    n_run++;
    if (bus.dout !== 8'h3C || sl_rx !== 8'h01) begin
      n_fail++;
      $display("FAIL lsb_slave: got dout=%h slave_rx=%h, want 3C 01", bus.dout, sl_rx);
    end
    bus.lsb_first = 1'b0;
  endtask
`endif

  initial begin
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.din = 8'h00;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.ss_sel = 2'd0;
`ifdef SPI_LSB_FIRST_EN
    bus.lsb_first = 1'b0;
`endif
    test_reset();
    test_mode0();
    test_mode3_mode1();
    test_wr_ignored();
    test_reset_abort();
    test_select();
    test_unselected();
    test_back_to_back();
`ifdef SPI_LSB_FIRST_EN
    test_lsb_first();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
